// File: rtl/pim_load_if.sv
// pim_load_if: bundle of the load-start strobe, the valid/ready source stream
// and the memory write port of pim_load_ctrl.
//
// Handshake: a word moves from source to block on a rising clock edge where
// in_valid and in_ready are both high. in_ready is driven from registered
// state only and never looks at in_valid. The source may raise or drop
// in_valid on any cycle. The block never stalls the write port: mem_we is a
// one-cycle strobe per word.
//
// Parameters: DATA_W (data word width), ADDR_W (memory address width).
// master: host/test side (drives start_Load, in_data, in_valid).
// slave : pim_load_ctrl side (drives in_ready, mem_*, busy, load_done, err_overlap).
interface pim_load_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              start_Load;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              busy;
  logic              load_done;
  logic              err_overlap;

  modport master (
    output start_Load, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, load_done, err_overlap
  );

  modport slave (
    input  start_Load, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, load_done, err_overlap
  );
endinterface

// File: rtl/pim_load_ctrl.sv
// pim_load_ctrl: on a rising edge of start_Load, copies NUM_WORDS words from
// a valid/ready source into the PIM memory write port starting at BASE_ADDR.
// Addresses wrap modulo 2^ADDR_W. Issues a one-cycle load_done pulse.
// Sets a sticky err_overlap if a start edge arrives while a burst is running.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : pim_load_if slave (start_Load, in_*, mem_*, busy, load_done, err_overlap)
//   dbg_state : current FSM state (0 IDLE, 1 LOAD, 2 DONE)
module pim_load_ctrl #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int NUM_WORDS = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic       clk,
  input  logic       rst,
  pim_load_if.slave  bus,
  output logic [1:0] dbg_state
);

  localparam int                CNT_W    = $clog2(NUM_WORDS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                start_prev_q, start_prev_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_overlap_q, err_overlap_d;

  logic start_edge;
  logic in_ready;
  logic xfer;

  // start_prev resets to 1 so a level held high through reset is not an edge.
  assign start_edge = bus.start_Load & ~start_prev_q;
  assign in_ready   = (state_q == LOAD);
  assign xfer       = bus.in_valid & in_ready;

  always_comb begin
    state_d       = state_q;
    start_prev_d  = bus.start_Load;
    addr_d        = addr_q;
    count_d       = count_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    err_overlap_d = err_overlap_q;

    case (state_q)
      IDLE: begin
        count_d = '0;
        addr_d  = BASE;
        if (start_edge) begin
          state_d       = LOAD;
          err_overlap_d = 1'b0;
        end
      end
      LOAD: begin
        // A second start during a burst is flagged but otherwise ignored.
        if (start_edge) err_overlap_d = 1'b1;
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.in_data;
          addr_d      = addr_q + ADDR_W'(1);
          count_d     = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) state_d = DONE;
        end
      end
      DONE: begin
        if (start_edge) err_overlap_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      start_prev_q  <= 1'b1;
      addr_q        <= BASE;
      count_q       <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      err_overlap_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_prev_q  <= start_prev_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      err_overlap_q <= err_overlap_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.load_done   = (state_q == DONE);
  assign bus.err_overlap = err_overlap_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_pim_load_ctrl.sv
module tb_pim_load_ctrl;

  localparam int A_DW   = 32;
  localparam int A_AW   = 8;
  localparam int A_NUM  = 16;
  localparam int A_BASE = 0;

  // ---------------- clock / reset ----------------
  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT A: default burst ----------------
  logic              drv_rst, drv_start, drv_valid;
  logic [A_DW-1:0]   drv_data;
  logic [1:0]        a_dbg_state;

  pim_load_if #(.DATA_W(A_DW), .ADDR_W(A_AW)) a_if ();
  assign a_if.start_Load = drv_start;
  assign a_if.in_valid   = drv_valid;
  assign a_if.in_data    = drv_data;

  pim_load_ctrl #(.DATA_W(A_DW), .ADDR_W(A_AW), .NUM_WORDS(A_NUM), .BASE_ADDR(A_BASE)) dut_a (
    .clk       (clk),
    .rst       (drv_rst),
    .bus       (a_if.slave),
    .dbg_state (a_dbg_state)
  );

  // ---------------- DUT B: wrap-around burst ----------------
  logic        b_rst, b_start, b_valid, b_done;
  logic [31:0] b_data;
  logic [1:0]  b_dbg_state;

  pim_load_if #(.DATA_W(32), .ADDR_W(4)) b_if ();
  assign b_if.start_Load = b_start;
  assign b_if.in_valid   = b_valid;
  assign b_if.in_data    = b_data;

  pim_load_ctrl #(.DATA_W(32), .ADDR_W(4), .NUM_WORDS(8), .BASE_ADDR(12)) dut_b (
    .clk       (clk),
    .rst       (b_rst),
    .bus       (b_if.slave),
    .dbg_state (b_dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model for DUT A ----------------
  // Burst-level view: "loading" while fewer than A_NUM words have been taken,
  // then one "finishing" cycle. The n-th word of a burst goes to (BASE+n) mod 2^AW.
  bit                   m_start_prev = 1'b1;
  bit                   m_loading    = 1'b0;
  bit                   m_finishing  = 1'b0;
  bit                   m_err        = 1'b0;
  int                   m_n          = 0;
  bit                   e_we         = 1'b0;
  logic [A_AW-1:0]      e_addr       = '0;
  logic [A_DW-1:0]      e_data       = '0;
  logic [A_AW+A_DW-1:0] exp_q[$];
  int                   wr_cnt       = 0;

  task automatic model_step();
    bit edge_s;
    edge_s       = drv_start && !m_start_prev;
    m_start_prev = drv_start;
    e_we         = 1'b0;
    if (drv_rst) begin
      m_start_prev = 1'b1;
      m_loading    = 1'b0;
      m_finishing  = 1'b0;
      m_err        = 1'b0;
      m_n          = 0;
      e_addr       = '0;
      e_data       = '0;
      exp_q.delete();
    end else if (m_finishing) begin
      if (edge_s) m_err = 1'b1;
      m_finishing = 1'b0;
    end else if (m_loading) begin
      if (edge_s) m_err = 1'b1;
      if (drv_valid) begin
        e_we   = 1'b1;
        e_addr = A_AW'((A_BASE + m_n) % (1 << A_AW));
        e_data = drv_data;
        exp_q.push_back({e_addr, e_data});
        m_n++;
        if (m_n == A_NUM) begin
          m_loading   = 1'b0;
          m_finishing = 1'b1;
        end
      end
    end else if (edge_s) begin
      m_loading = 1'b1;
      m_n       = 0;
      m_err     = 1'b0;
    end
  endtask

  task automatic check_outputs();
    logic [A_AW+A_DW-1:0] w;
    check_eq("in_ready",    64'(a_if.in_ready),    64'(m_loading));
    check_eq("busy",        64'(a_if.busy),        64'(m_loading | m_finishing));
    check_eq("load_done",   64'(a_if.load_done),   64'(m_finishing));
    check_eq("err_overlap", 64'(a_if.err_overlap), 64'(m_err));
    check_eq("mem_we",      64'(a_if.mem_we),      64'(e_we));
    if (a_if.mem_we) wr_cnt++;
    if (e_we) begin
      w = exp_q.pop_front();
      check_eq("mem_addr",  64'(a_if.mem_addr),  64'(w[A_AW+A_DW-1:A_DW]));
      check_eq("mem_wdata", 64'(a_if.mem_wdata), 64'(w[A_DW-1:0]));
    end else begin
      check_eq("mem_addr_hold",  64'(a_if.mem_addr),  64'(e_addr));
      check_eq("mem_wdata_hold", 64'(a_if.mem_wdata), 64'(e_data));
    end
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic step(input bit r, input bit s, input bit v, input logic [A_DW-1:0] d);
    drv_rst   = r;
    drv_start = s;
    drv_valid = v;
    drv_data  = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic start_burst();
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
  endtask

  // mode 0: in_valid held high; mode 1: in_valid follows 1,0,0,1 pattern.
  task automatic finish_burst(input int mode);
    int p;
    p = 0;
    while ((m_loading || m_finishing) && p < 300) begin
      step(1'b0, drv_start, (mode == 0) || (p % 4 == 0) || (p % 4 == 3), 32'h100 + 32'(m_n));
      p++;
    end
  endtask

  // ---------------- DUT B directed wrap-around ----------------
  initial begin
    int idx;
    int wrap_addr[8];
    wrap_addr = '{12, 13, 14, 15, 0, 1, 2, 3};
    b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = '0; b_done = 1'b0;
    repeat (3) @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    b_valid = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      b_data = 32'h200 + 32'(cyc);
      @(negedge clk);
      if (b_if.mem_we) begin
        if (idx < 8) begin
          check_eq("wrap_addr", 64'(b_if.mem_addr), 64'(wrap_addr[idx]));
          check_eq("wrap_done", 64'(b_if.load_done), 64'(idx == 7));
        end
        idx++;
      end
    end
    check_eq("wrap_writes", 64'(idx), 64'(8));
    check_eq("wrap_busy_end", 64'(b_if.busy), 64'(0));
    b_done = 1'b1;
  end

  // ---------------- main sequence for DUT A ----------------
  initial begin
    drv_rst = 1'b1; drv_start = 1'b0; drv_valid = 1'b0; drv_data = '0;
    @(negedge clk);

    // reset state
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    check_eq("rst_busy", 64'(a_if.busy), 64'(0));

    // reset then start, in_valid held high
    wr_cnt = 0;
    start_burst();
    finish_burst(0);
    check_eq("burst1_writes", 64'(wr_cnt), 64'(16));

    // stall handling
    wr_cnt = 0;
    start_burst();
    finish_burst(1);
    check_eq("stall_writes", 64'(wr_cnt), 64'(16));

    // start held high through reset
    step(1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 32'h55);
    check_eq("held_start_busy", 64'(a_if.busy), 64'(0));
    wr_cnt = 0;
    start_burst();
    finish_burst(0);
    check_eq("held_start_writes", 64'(wr_cnt), 64'(16));

    // overlap at word 5
    wr_cnt = 0;
    start_burst();
    while (m_n < 5) step(1'b0, 1'b1, 1'b1, 32'h100 + 32'(m_n));
    step(1'b0, 1'b0, 1'b1, 32'h100 + 32'(m_n));
    step(1'b0, 1'b1, 1'b1, 32'h100 + 32'(m_n));
    finish_burst(0);
    check_eq("ovl_writes", 64'(wr_cnt), 64'(16));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
    check_eq("ovl_sticky", 64'(a_if.err_overlap), 64'(1));
    start_burst();
    check_eq("ovl_clear", 64'(a_if.err_overlap), 64'(0));
    finish_burst(0);

    // reset mid-burst after 7 transfers
    start_burst();
    while (m_n < 7) step(1'b0, 1'b1, 1'b1, 32'h100 + 32'(m_n));
    step(1'b1, 1'b1, 1'b1, '0);
    check_eq("midrst_we", 64'(a_if.mem_we), 64'(0));
    check_eq("midrst_done", 64'(a_if.load_done), 64'(0));
    check_eq("midrst_addr", 64'(a_if.mem_addr), 64'(0));
    start_burst();
    step(1'b0, 1'b1, 1'b1, 32'h100);
    check_eq("midrst_restart_addr", 64'(a_if.mem_addr), 64'(A_BASE));
    finish_burst(0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic s;
      s = drv_start;
      if ($urandom_range(0, 19) == 0) s = ~s;
      step($urandom_range(0, 299) == 0, s, 1'($urandom_range(0, 1)), $urandom);
    end
    finish_burst(0);

    wait (b_done);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
